// File: rtl/keyed_secded_pipe_if.sv
// keyed_secded_pipe_if: valid/ready stream bundle for the keyed SEC-DED pipeline
// in_*  : received word + check bits toward the block (slave consumes)
// out_* : corrected word + error flags from the block (slave produces)
interface keyed_secded_pipe_if #(
  parameter int DATA_W = 32
);
  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction
  localparam int CHK_W = calc_p(DATA_W) + 1;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CHK_W-1:0]  in_chk;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sb_err;
  logic              out_db_err;
  modport master (
    output in_valid, in_data, in_chk, out_ready,
    input  in_ready, out_valid, out_data, out_sb_err, out_db_err
  );
  modport slave (
    input  in_valid, in_data, in_chk, out_ready,
    output in_ready, out_valid, out_data, out_sb_err, out_db_err
  );
endinterface

// File: rtl/keyed_secded_pipe.sv
// keyed_secded_pipe: two-stage SEC-DED check/correct pipeline with a locking key and saturating error counters
// clk, rst_n            : clock, async active-low reset
// bus (slave)           : in_valid/in_ready/in_data/in_chk, out_valid/out_ready/out_data/out_sb_err/out_db_err
// corr_en               : 1 corrects single data-bit errors, 0 only reports
// key_load, key_in      : load the unlocking key register
// corr_cnt, uncorr_cnt  : saturating corrected / uncorrectable word counts
// cnt_clr               : synchronous clear of both counters
module keyed_secded_pipe #(
  parameter int                DATA_W   = 32,
  parameter int                CNT_W    = 16,
  parameter logic [DATA_W-1:0] KEY_MASK = 32'hA5C3_0F96
) (
  input  logic                   clk,
  input  logic                   rst_n,
  keyed_secded_pipe_if.slave     bus,
  input  logic                   corr_en,
  input  logic                   key_load,
  input  logic [DATA_W-1:0]      key_in,
  output logic [CNT_W-1:0]       corr_cnt,
  output logic [CNT_W-1:0]       uncorr_cnt,
  input  logic                   cnt_clr
);
  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction
  localparam int P = calc_p(DATA_W);
  localparam int N = DATA_W + P;
  localparam logic [P-1:0] NP = P'(N);
  // codeword position of each data bit: the non-power-of-2 slots in ascending order
  function automatic logic [DATA_W-1:0][P-1:0] calc_pos();
    logic [DATA_W-1:0][P-1:0] r;
    int k;
    r = '0;
    k = 0;
    for (int q = 1; q <= N; q++)
      if ((q & (q - 1)) != 0) begin
        r[k] = P'(q);
        k++;
      end
    return r;
  endfunction
  localparam logic [DATA_W-1:0][P-1:0] POS = calc_pos();
  logic [DATA_W-1:0] key_reg, delta, d1, od, fix;
  logic [P-1:0]      rc, syn, s1;
  logic              pm, sb0, db0, v1, sb1, db1, ce1, ov, osb, odb, adv;
  assign delta = key_reg ^ KEY_MASK;
  assign adv   = !ov | bus.out_ready;
  assign bus.in_ready   = adv;
  assign bus.out_valid  = ov;
  assign bus.out_data   = od;
  assign bus.out_sb_err = osb;
  assign bus.out_db_err = odb;
  // a wrong key perturbs syndrome and parity, so a locked block misclassifies clean words
  always_comb begin
    rc = '0;
    for (int j = 0; j < DATA_W; j++)
      for (int i = 0; i < P; i++)
        if (POS[j][i]) rc[i] = rc[i] ^ bus.in_data[j];
    syn = rc ^ bus.in_chk[P-1:0] ^ delta[P-1:0];
    pm  = ^bus.in_data ^ ^bus.in_chk ^ delta[P];
    sb0 = pm && (syn <= NP);
    db0 = (syn != '0 && !pm) || (pm && syn > NP);
  end
  // syndromes naming a check-bit slot (or zero) match no data position, so leave data alone
  always_comb begin
    fix = '0;
    for (int j = 0; j < DATA_W; j++) fix[j] = ce1 && sb1 && (s1 == POS[j]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg    <= '0;
      v1         <= 1'b0;
      d1         <= '0;
      s1         <= '0;
      sb1        <= 1'b0;
      db1        <= 1'b0;
      ce1        <= 1'b0;
      ov         <= 1'b0;
      od         <= '0;
      osb        <= 1'b0;
      odb        <= 1'b0;
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else begin
      if (key_load) key_reg <= key_in;
      if (adv) begin
        v1  <= bus.in_valid;
        d1  <= bus.in_data ^ delta;
        s1  <= syn;
        sb1 <= bus.in_valid & sb0;
        db1 <= bus.in_valid & db0;
        ce1 <= corr_en;
        ov  <= v1;
        od  <= d1 ^ fix;
        osb <= v1 & sb1;
        odb <= v1 & db1;
      end
      if (cnt_clr) corr_cnt <= '0;
      else if (adv && v1 && sb1 && corr_cnt != '1) corr_cnt <= corr_cnt + 1'b1;
      if (cnt_clr) uncorr_cnt <= '0;
      else if (adv && v1 && db1 && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_keyed_secded_pipe.sv
// tb_keyed_secded_pipe: directed table-driven checks of the keyed SEC-DED pipeline
module tb_keyed_secded_pipe;
  localparam int CW = 4;
  localparam logic [31:0] KEY = 32'hA5C3_0F96;
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] dflip;
    logic [6:0]  cflip;
    logic        corr;
    logic [31:0] exp_d;
    logic        sb;
    logic        db;
    logic [3:0]  cc;
    logic [3:0]  uc;
  } vec_t;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          corr_en = 1'b1;
  logic          key_load = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [31:0]   key_in = '0;
  logic [CW-1:0] corr_cnt, uncorr_cnt;
  int            checks = 0;
  int            errors = 0;
  vec_t          vecs[9];
  logic [31:0]   words[6];
  keyed_secded_pipe_if #(.DATA_W(32)) bus();
  keyed_secded_pipe #(.DATA_W(32), .CNT_W(CW), .KEY_MASK(KEY)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .corr_en(corr_en), .key_load(key_load),
    .key_in(key_in), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .cnt_clr(cnt_clr)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [6:0] c;
    int k;
    c = '0;
    k = 0;
    for (int q = 1; q <= 38; q++)
      if ((q & (q - 1)) != 0) begin
        for (int i = 0; i < 6; i++) if (q[i]) c[i] = c[i] ^ d[k];
        k++;
      end
    c[6] = ^d ^ ^c[5:0];
    return c;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_vec(input string tag, input vec_t v);
    bus.in_valid = 1'b1;
    bus.in_data  = v.data ^ v.dflip;
    bus.in_chk   = enc(v.data) ^ v.cflip;
    corr_en      = v.corr;
    step();
    bus.in_valid = 1'b0;
    key_load     = 1'b0;
    chk({tag, " lat1_valid"}, 32'(bus.out_valid), 32'd0);
    step();
    chk({tag, " lat2_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, " data"}, bus.out_data, v.exp_d);
    chk({tag, " sb"}, 32'(bus.out_sb_err), 32'(v.sb));
    chk({tag, " db"}, 32'(bus.out_db_err), 32'(v.db));
    chk({tag, " corr_cnt"}, 32'(corr_cnt), 32'(v.cc));
    chk({tag, " uncorr_cnt"}, 32'(uncorr_cnt), 32'(v.uc));
  endtask
  initial begin
    int sent, rcv, stall;
    bit seen, have_prev;
    logic [31:0] prev;
    vecs[0] = '{32'hDEADBEEF, 32'h0, 7'h00, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0, 4'd0};
    vecs[1] = '{32'hDEADBEEF, 32'h20, 7'h00, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 4'd1, 4'd0};
    vecs[2] = '{32'hDEADBEEF, 32'h20, 7'h00, 1'b0, 32'hDEADBECF, 1'b1, 1'b0, 4'd2, 4'd0};
    vecs[3] = '{32'hDEADBEEF, 32'h3, 7'h00, 1'b1, 32'hDEADBEEC, 1'b0, 1'b1, 4'd2, 4'd1};
    vecs[4] = '{32'hDEADBEEF, 32'h0, 7'h40, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 4'd3, 4'd1};
    vecs[5] = '{32'hDEADBEEF, 32'h0, 7'h01, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 4'd4, 4'd1};
    vecs[6] = '{32'h00000000, 32'h0, 7'h00, 1'b1, 32'h00000000, 1'b0, 1'b0, 4'd4, 4'd1};
    vecs[7] = '{32'h12345678, 32'h80000000, 7'h00, 1'b1, 32'h12345678, 1'b1, 1'b0, 4'd5, 4'd1};
    vecs[8] = '{32'h12345678, 32'hE0000000, 7'h00, 1'b1, 32'hF2345678, 1'b0, 1'b1, 4'd5, 4'd2};
    for (int k = 0; k < 6; k++) words[k] = 32'h1111_1111 * (k + 1) ^ 32'hC000_0005;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_chk    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_reset corr_cnt", 32'(corr_cnt), 32'd0);
    chk("post_reset uncorr_cnt", 32'(uncorr_cnt), 32'd0);
    run_vec("locked", '{32'hDEADBEEF, 32'h0, 7'h00, 1'b1, 32'h7B6EB179, 1'b0, 1'b1, 4'd0, 4'd1});
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr uncorr_cnt", 32'(uncorr_cnt), 32'd0);
    key_load = 1'b1;
    key_in   = KEY;
    step();
    key_load = 1'b0;
    for (int k = 0; k < 9; k++) run_vec($sformatf("vec%0d", k), vecs[k]);
    corr_en = 1'b1;
    step();
    sent = 0; rcv = 0; stall = 0; seen = 0; have_prev = 0; prev = '0;
    for (int c = 0; c < 40 && rcv < 6; c++) begin
      if (bus.out_valid && !seen) begin
        seen  = 1;
        stall = 3;
      end
      bus.out_ready = (stall == 0);
      bus.in_valid  = (sent < 6);
      if (sent < 6) begin
        bus.in_data = words[sent];
        bus.in_chk  = enc(words[sent]);
      end
      @(negedge clk);
      if (bus.out_valid && !bus.out_ready) begin
        chk("stall in_ready", 32'(bus.in_ready), 32'd0);
        if (have_prev) chk("stall hold", bus.out_data, prev);
        prev = bus.out_data;
        have_prev = 1;
        stall--;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("bp word%0d", rcv), bus.out_data, words[rcv]);
        rcv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp delivered", 32'(rcv), 32'd6);
    chk("bp stalled", 32'(have_prev), 32'd1);
    chk("bp no_dup", 32'(bus.out_valid), 32'd0);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(k * 7 + 1);
      bus.in_chk   = enc(32'(k * 7 + 1)) ^ 7'h40;
      step();
    end
    bus.in_valid = 1'b0;
    step();
    step();
    chk("sat corr_cnt", 32'(corr_cnt), 32'd15);
    chk("sat uncorr_cnt", 32'(uncorr_cnt), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEADBEEF;
    bus.in_chk   = enc(32'hDEADBEEF) ^ 7'h40;
    step();
    bus.in_valid = 1'b0;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_vs_inc corr_cnt", 32'(corr_cnt), 32'd0);
    chk("clr_vs_inc sb", 32'(bus.out_sb_err), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEADBEEF;
    bus.in_chk   = enc(32'hDEADBEEF) ^ 7'h01;
    step();
    step();
    chk("midrst pre out_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst out_data", bus.out_data, 32'd0);
    chk("midrst sb", 32'(bus.out_sb_err), 32'd0);
    chk("midrst corr_cnt", 32'(corr_cnt), 32'd0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("post_midrst idle%0d", k), 32'(bus.out_valid), 32'd0);
      chk($sformatf("post_midrst ready%0d", k), 32'(bus.in_ready), 32'd1);
    end
    key_load = 1'b1;
    key_in   = KEY;
    run_vec("oldkey", '{32'hDEADBEEF, 32'h0, 7'h00, 1'b1, 32'h7B6EB179, 1'b0, 1'b1, 4'd0, 4'd1});
    run_vec("newkey", '{32'hDEADBEEF, 32'h0, 7'h00, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0, 4'd1});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
